// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding memory
// request FSM and a small circular byte buffer feeding the decoder.
module fetch_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter int                  DEPTH    = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [7:0]          mem_rdata,
  output logic [7:0]          instr,
  output logic                instr_valid,
  output logic                fetch_source
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISC} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q;
  logic [PC_WIDTH-1:0] mem_addr_q;
  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic [PW-1:0]       head_q, tail_q;
  logic [CW-1:0]       count_q;
  logic [7:0]          buf_q [DEPTH];

  logic issue, push, pop;

  // Next-state decode; space is only checked when a request is issued.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!redirect && (count_q < CW'(DEPTH))) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect)     state_d = mem_ack ? S_IDLE : S_DISC;
        else if (mem_ack) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DISC: begin
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A redirect flushes the head anyway, so it never counts as a pop here.
  assign pop = instr_valid && !stall && !redirect;

  // State register; mem_req is registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d != S_IDLE);
    end
  end

  // Program counter and captured request address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
    end else begin
      if (redirect)  fetch_pc_q <= redirect_pc;
      else if (push) fetch_pc_q <= fetch_pc_q + PC_WIDTH'(1);
      if (issue)     mem_addr_q <= fetch_pc_q;
    end
  end

  // Buffer pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk) begin
    if (!reset || redirect) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Buffer storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (push) buf_q[tail_q] <= mem_rdata;
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign instr_valid  = (count_q != '0);
  assign fetch_source = instr_valid;
  assign instr        = instr_valid ? buf_q[head_q] : 8'h00;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       reset, stall, redirect, mem_ack;
  logic [7:0] redirect_pc, mem_rdata;
  logic       mem_req, instr_valid, fetch_source;
  logic [7:0] mem_addr, instr;

  int n_checks = 0;
  int n_err    = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr),
    .instr_valid(instr_valid), .fetch_source(fetch_source)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: transaction-level view of the fetch stage.
  logic [7:0] q[$];
  bit         m_on = 0;
  bit         m_busy, m_stale;
  logic [7:0] m_pc, m_addr;

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_busy = 0; m_stale = 0; m_pc = 8'h00; m_addr = 8'h00; m_on = 1;
    end else if (m_on) begin
      if (redirect) begin
        q.delete();
        m_pc = redirect_pc;
        if (m_busy) begin
          if (mem_ack) begin m_busy = 0; m_stale = 0; end
          else m_stale = 1;
        end
      end else begin
        bit do_pop, do_push;
        do_pop  = (q.size() > 0) && !stall;
        do_push = 0;
        if (m_busy) begin
          if (mem_ack) begin
            m_busy = 0;
            if (!m_stale) begin do_push = 1; m_pc = m_pc + 8'd1; end
            m_stale = 0;
          end
        end else if (q.size() < DEPTH) begin
          m_busy = 1; m_stale = 0; m_addr = m_pc;
        end
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(mem_rdata);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("m_req",   mem_req,      m_busy);
      chk("m_addr",  mem_addr,     m_addr);
      chk("m_valid", instr_valid,  q.size() != 0);
      chk("m_src",   fetch_source, q.size() != 0);
      chk("m_instr", instr,        (q.size() != 0) ? q[0] : 8'h00);
    end
  end

  initial begin
    reset = 0; stall = 0; redirect = 0; redirect_pc = 0; mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    chk("rst_req", mem_req, 0);      chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 8'h00);  chk("rst_src", fetch_source, 0);
    chk("rst_addr", mem_addr, 8'h00);

    // fill under backpressure
    reset = 1; stall = 1; tick();
    chk("first_req", mem_req, 1);    chk("first_addr", mem_addr, 8'h00);
    mem_ack = 1; mem_rdata = 8'hA1; tick(); mem_ack = 0;
    chk("fill_a1", instr, 8'hA1);    chk("fill_idle", mem_req, 0);
    tick();
    chk("req1", mem_req, 1);         chk("req1_addr", mem_addr, 8'h01);
    mem_ack = 1; mem_rdata = 8'hB2; tick(); mem_ack = 0;
    tick(); tick();
    chk("no_third", mem_req, 0);     chk("held_a1", instr, 8'hA1);
    stall = 0; tick(); stall = 1;
    chk("pop_b2", instr, 8'hB2);     chk("pop_noreq", mem_req, 0);
    tick();
    chk("req2", mem_req, 1);         chk("req2_addr", mem_addr, 8'h02);

    // push and pop in the same cycle
    stall = 0; mem_ack = 1; mem_rdata = 8'hC3; tick(); mem_ack = 0; stall = 1;
    chk("pushpop", instr, 8'hC3);    chk("pushpop_v", instr_valid, 1);
    tick();
    chk("req3_addr", mem_addr, 8'h03);

    // redirect mid-fetch
    redirect = 1; redirect_pc = 8'h05; tick(); redirect = 0;
    chk("disc_req", mem_req, 1);     chk("disc_addr", mem_addr, 8'h03);
    chk("flush", instr_valid, 0);
    mem_ack = 1; mem_rdata = 8'h77; tick(); mem_ack = 0;
    chk("disc_done", mem_req, 0);
    tick();
    chk("redir_addr", mem_addr, 8'h05);
    redirect = 1; redirect_pc = 8'h40; tick(); redirect = 0;
    tick(); tick();
    mem_ack = 1; mem_rdata = 8'hEE; tick(); mem_ack = 0;
    chk("ee_dropped", instr_valid, 0);
    tick();
    chk("req40", mem_req, 1);        chk("req40_addr", mem_addr, 8'h40);

    // redirect with coincident ack
    redirect = 1; redirect_pc = 8'h10; mem_ack = 1; mem_rdata = 8'h55; tick();
    redirect = 0; mem_ack = 0;
    chk("coin_req", mem_req, 0);     chk("coin_valid", instr_valid, 0);
    tick();
    chk("req10_addr", mem_addr, 8'h10);
    redirect = 1; redirect_pc = 8'hFF; mem_ack = 1; mem_rdata = 8'h99; tick();
    redirect = 0; mem_ack = 0;
    chk("coin2_valid", instr_valid, 0);
    tick();
    chk("reqff_addr", mem_addr, 8'hFF);

    // wrap
    mem_ack = 1; mem_rdata = 8'h11; tick(); mem_ack = 0;
    chk("wrap_instr", instr, 8'h11);
    tick();
    chk("wrap_req", mem_req, 1);     chk("wrap_addr", mem_addr, 8'h00);

    // reset while waiting
    reset = 0; tick(); tick();
    chk("rst2_req", mem_req, 0);     chk("rst2_valid", instr_valid, 0);
    reset = 1;

    // randomized traffic, including spurious acks and occasional resets
    for (int i = 0; i < 4000; i++) begin
      reset       = ($urandom_range(0, 399) != 0);
      stall       = ($urandom_range(0, 3) == 0) || (i[9] && $urandom_range(0, 1) == 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = 8'($urandom);
      mem_ack     = ($urandom_range(0, 2) == 0);
      mem_rdata   = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the decoder. Holds the program counter, fetches 8-bit instruction bytes from program memory over a single-outstanding req/ack handshake, and buffers them in a small FIFO. Presents the head byte to the decoder as `instr` with `fetch_source`, and pops it unless the downstream `stall` is asserted. A `redirect` input (branch/jump) reloads the PC and flushes all buffered and in-flight bytes.

## Interface
- `PC_WIDTH`, 8, program counter and memory address width
- `DEPTH`, 2, instruction buffer entries; a power of two, at least 2
- `RESET_PC`, 0, PC value loaded on reset

- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-low reset: low at a rising edge resets the block
- `stall`  in  1  downstream cannot accept the head byte this cycle
- `redirect`  in  1  load `redirect_pc` into PC and flush the buffer
- `redirect_pc`  in  PC_WIDTH  new fetch address
- `mem_req`  out  1  read request to program memory
- `mem_addr`  out  PC_WIDTH  read address, held stable while `mem_req` is high
- `mem_ack`  in  1  `mem_rdata` valid; completes the request
- `mem_rdata`  in  8  instruction byte
- `instr`  out  8  buffer head byte; 8'h00 when the buffer is empty
- `instr_valid`  out  1  buffer is non-empty
- `fetch_source`  out  1  equals `instr_valid`; drives the decoder's PC-increment path

## Operation
- Storage: `DEPTH`×8 circular buffer with head and tail pointers and `count` (0..DEPTH). Pointers wrap modulo DEPTH.
- `fetch_pc` is the address of the next byte to request. `mem_addr` is a separate register captured when a request is issued.
- FSM states:
  - IDLE: `mem_req`=0. If `count` < DEPTH and `redirect`=0, set `mem_req`=1 and `mem_addr`=`fetch_pc`, then go to WAIT.
  - WAIT: `mem_req`=1. On `mem_ack`, write `mem_rdata` at tail, set `fetch_pc`+=1 (modulo 2^PC_WIDTH, so 0xFF→0x00), clear `mem_req`, and go to IDLE.
  - DISCARD: `mem_req`=1 with the old `mem_addr`. On `mem_ack`, drop the data, clear `mem_req`, and go to IDLE.
- Space is checked only at issue. Because at most one request is outstanding and `count` can only fall meanwhile, a write on ack always fits.
- Pop: when `instr_valid`=1 and `stall`=0, advance head at the clock edge. A push and a pop in the same cycle leave `count` unchanged.
- `redirect` has highest priority. At the next edge:
  - `count`=0, pointers reset, `fetch_pc`=`redirect_pc`.
  - From WAIT without `mem_ack` in the same cycle: go to DISCARD.
  - From WAIT with `mem_ack` in the same cycle: data dropped, PC not incremented, go to IDLE.
  - From DISCARD: `fetch_pc` updated, stay in DISCARD (an ack in the same cycle → IDLE).
  - From IDLE: no request is issued that cycle; stay in IDLE.
  - A head byte visible in the redirect cycle with `stall`=0 counts as consumed by the decoder. It is flushed regardless.
- Reset values: `fetch_pc`=RESET_PC, `mem_addr`=RESET_PC, `mem_req`=0, `count`=0, head=tail=0, state IDLE. Hence `instr`=8'h00, `instr_valid`=0, `fetch_source`=0.
- Reset during WAIT/DISCARD abandons the transaction. Program memory must also be reset by the same signal.

## Timing
- `mem_req` and `mem_addr` are registered outputs. `instr`, `instr_valid` and `fetch_source` are combinational from registered buffer state; there is no input-to-output path.
- Fetch latency: first request on the first edge after reset deasserts. With `mem_ack` in the first WAIT cycle, the byte is visible on `instr` in the cycle after the ack edge.
- Minimum spacing is 2 cycles per request (WAIT, IDLE), so peak throughput is 1 byte per 2 cycles.
- Ack latency is unbounded; `mem_req`/`mem_addr` are held until ack.
- `mem_ack` while `mem_req`=0 is ignored.
- First request after a redirect: the edge after leaving DISCARD/IDLE, at address `redirect_pc`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, release → all outputs at reset values; `mem_req`=1 with `mem_addr`=0x00 one edge later.
- Fill/backpressure: `stall`=1, memory acks in 1 cycle with data 0xA1, 0xB2 → addresses 0x00, 0x01 requested; no third request; `instr`=0xA1 held. Release `stall` for one cycle → `instr`=0xB2 and a request for 0x02 is issued.
- Push+pop: `stall`=0, `count`=1, ack arrives in the same cycle as the pop → `count` stays 1; byte order preserved.
- Redirect mid-fetch: in WAIT at 0x05, pulse `redirect` with `redirect_pc`=0x40, ack 3 cycles later with 0xEE → 0xEE never appears on `instr`; next `mem_addr`=0x40.
- Redirect with coincident ack: WAIT at 0x10, `redirect`=1 and `mem_ack`=1 in the same cycle → buffer empty, next request to `redirect_pc`.
- Wrap: redirect to 0xFF, ack 0x11 → next request `mem_addr`=0x00.
